// File: rtl/mfp_ahb_cache_perf.sv
// rtl/mfp_ahb_cache_perf.sv - AHB-Lite performance counter slave for cycle/D$ hit/miss/run events
// Live counters run while enabled; software reads atomic shadow snapshots and sticky wrap flags.
module mfp_ahb_cache_perf #(
  parameter bit EN_AT_RESET = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic        mpc_run_m,
  input  logic        dcc_pm_dhit_m,
  input  logic        dcc_dmiss_m,
  output logic        perf_irq
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CYC    = 3'd2;
  localparam logic [2:0] OFF_HIT    = 3'd3;
  localparam logic [2:0] OFF_MISS   = 3'd4;
  localparam logic [2:0] OFF_RUN    = 3'd5;

  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  logic        dp_word_q,  dp_word_d;
  logic [2:0]  dp_off_q,   dp_off_d;
  logic        rd_live_q,  rd_live_d;

  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic [3:0]  status_q, status_d;
  logic        miss_dly_q, miss_dly_d;
  logic        perf_irq_q, perf_irq_d;

  logic [31:0] cyc_q, cyc_d, hit_q, hit_d, miss_q, miss_d, run_q, run_d;
  logic [31:0] cyc_sh_q, cyc_sh_d, hit_sh_q, hit_sh_d;
  logic [31:0] miss_sh_q, miss_sh_d, run_sh_q, run_sh_d;

  logic        addr_accept;
  logic        wr_en, wr_ctrl, wr_status, snap, clr;
  logic [3:0]  inc, wrap, w1c;
  logic        unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign perf_irq  = perf_irq_q;
  assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:4]};

  assign addr_accept = HSEL & HREADY & HTRANS[1];

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_word_d  = dp_word_q;
    dp_off_d   = dp_off_q;
    rd_live_d  = rd_live_q;
    if (HREADY) begin
      dp_valid_d = addr_accept;
      if (addr_accept) begin
        dp_write_d = HWRITE;
        dp_word_d  = (HSIZE == 3'b010);
        dp_off_d   = HADDR[4:2];
        rd_live_d  = 1'b1;
      end
    end
  end

  assign wr_en     = dp_valid_q & dp_write_q & dp_word_q;
  assign wr_ctrl   = wr_en & (dp_off_q == OFF_CTRL);
  assign wr_status = wr_en & (dp_off_q == OFF_STATUS);
  assign snap      = wr_ctrl & HWDATA[1];
  assign clr       = wr_ctrl & HWDATA[2];
  assign w1c       = wr_status ? HWDATA[3:0] : 4'b0000;

  // Bit order matches STATUS: CYC, HIT, MISS, RUN; a miss counts only on its rising edge.
  assign inc  = en_q ? {mpc_run_m, dcc_dmiss_m & ~miss_dly_q, dcc_pm_dhit_m & mpc_run_m, 1'b1}
                     : 4'b0000;
  assign wrap = {4{~clr}} & inc & {&run_q, &miss_q, &hit_q, &cyc_q};

  always_comb begin
    cyc_d  = clr ? 32'd0 : cyc_q  + {31'd0, inc[0]};
    hit_d  = clr ? 32'd0 : hit_q  + {31'd0, inc[1]};
    miss_d = clr ? 32'd0 : miss_q + {31'd0, inc[2]};
    run_d  = clr ? 32'd0 : run_q  + {31'd0, inc[3]};
  end

  // Shadows take the pre-increment, pre-clear live values.
  always_comb begin
    cyc_sh_d  = snap ? cyc_q  : cyc_sh_q;
    hit_sh_d  = snap ? hit_q  : hit_sh_q;
    miss_sh_d = snap ? miss_q : miss_sh_q;
    run_sh_d  = snap ? run_q  : run_sh_q;
  end

  always_comb begin
    en_d       = wr_ctrl ? HWDATA[0] : en_q;
    irq_en_d   = wr_ctrl ? HWDATA[3] : irq_en_q;
    status_d   = (status_q & ~w1c) | wrap;
    miss_dly_d = clr ? 1'b0 : dcc_dmiss_m;
    perf_irq_d = irq_en_q & (|status_q);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_word_q  <= 1'b0;
      dp_off_q   <= 3'd0;
      rd_live_q  <= 1'b0;
      en_q       <= EN_AT_RESET;
      irq_en_q   <= 1'b0;
      status_q   <= 4'b0000;
      miss_dly_q <= 1'b0;
      perf_irq_q <= 1'b0;
      cyc_q      <= 32'd0;
      hit_q      <= 32'd0;
      miss_q     <= 32'd0;
      run_q      <= 32'd0;
      cyc_sh_q   <= 32'd0;
      hit_sh_q   <= 32'd0;
      miss_sh_q  <= 32'd0;
      run_sh_q   <= 32'd0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_word_q  <= dp_word_d;
      dp_off_q   <= dp_off_d;
      rd_live_q  <= rd_live_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      status_q   <= status_d;
      miss_dly_q <= miss_dly_d;
      perf_irq_q <= perf_irq_d;
      cyc_q      <= cyc_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      run_q      <= run_d;
      cyc_sh_q   <= cyc_sh_d;
      hit_sh_q   <= hit_sh_d;
      miss_sh_q  <= miss_sh_d;
      run_sh_q   <= run_sh_d;
    end
  end

  // The mux follows the last accepted offset so HRDATA holds across idle cycles.
  always_comb begin
    HRDATA = 32'd0;
    if (rd_live_q) begin
      case (dp_off_q)
        OFF_CTRL:   HRDATA = {28'd0, irq_en_q, 2'b00, en_q};
        OFF_STATUS: HRDATA = {28'd0, status_q};
        OFF_CYC:    HRDATA = cyc_sh_q;
        OFF_HIT:    HRDATA = hit_sh_q;
        OFF_MISS:   HRDATA = miss_sh_q;
        OFF_RUN:    HRDATA = run_sh_q;
        default:    HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_ahb_cache_perf.sv
// tb/tb_mfp_ahb_cache_perf.sv - self-checking bench for mfp_ahb_cache_perf
// Directed scenarios plus random bus/event traffic against a behavioural register model.
module tb_mfp_ahb_cache_perf;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'd0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HWDATA = 32'd0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP, perf_irq;
  logic        mpc_run_m = 1'b0, dcc_pm_dhit_m = 1'b0, dcc_dmiss_m = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_cache_perf #(.EN_AT_RESET(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .mpc_run_m(mpc_run_m),
    .dcc_pm_dhit_m(dcc_pm_dhit_m), .dcc_dmiss_m(dcc_dmiss_m), .perf_irq(perf_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: index 0..3 = CYC, HIT, MISS, RUN
  logic [31:0] m_live [4];
  logic [31:0] m_shadow [4];
  logic [3:0]  m_status;
  logic        m_en, m_irq_en, m_irq, m_prev_miss;
  logic        m_pend, m_pend_wr, m_pend_word;
  logic [2:0]  m_pend_off;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_live[i] = 0;
      m_shadow[i] = 0;
    end
    m_status = 0; m_en = 1'b1; m_irq_en = 1'b0; m_irq = 1'b0; m_prev_miss = 1'b0;
    m_pend = 1'b0; m_pend_wr = 1'b0; m_pend_word = 1'b0; m_pend_off = 0;
  endtask

  task automatic model_step();
    bit do_wr, do_snap, do_clr;
    bit counts [4];
    logic [3:0] nstat;
    longint unsigned sum;
    do_wr   = m_pend && m_pend_wr && m_pend_word;
    do_snap = do_wr && m_pend_off == 0 && HWDATA[1];
    do_clr  = do_wr && m_pend_off == 0 && HWDATA[2];
    counts[0] = m_en;
    counts[1] = m_en && dcc_pm_dhit_m && mpc_run_m;
    counts[2] = m_en && dcc_dmiss_m && !m_prev_miss;
    counts[3] = m_en && mpc_run_m;
    nstat = m_status;
    if (do_wr && m_pend_off == 1) nstat = nstat & ~HWDATA[3:0];
    m_irq = m_irq_en && (m_status != 0);
    for (int i = 0; i < 4; i++) begin
      if (do_snap) m_shadow[i] = m_live[i];
      if (do_clr) m_live[i] = 0;
      else if (counts[i]) begin
        sum = longint'(m_live[i]) + 1;
        if (sum >= 64'h1_0000_0000) nstat[i] = 1'b1;
        m_live[i] = sum[31:0];
      end
    end
    m_status = nstat;
    m_prev_miss = do_clr ? 1'b0 : dcc_dmiss_m;
    if (do_wr && m_pend_off == 0) begin
      m_en = HWDATA[0];
      m_irq_en = HWDATA[3];
    end
    if (HREADY) begin
      m_pend = HSEL && HTRANS[1];
      if (m_pend) begin
        m_pend_wr = HWRITE;
        m_pend_word = (HSIZE == 3'b010);
        m_pend_off = HADDR[4:2];
      end
    end
  endtask

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) model_reset();
    else model_step();
  end

  function automatic logic [31:0] m_reg(input logic [2:0] off);
    case (off)
      3'd0: return {28'd0, m_irq_en, 2'b00, m_en};
      3'd1: return {28'd0, m_status};
      3'd2, 3'd3, 3'd4, 3'd5: return m_shadow[int'(off) - 2];
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] nxt_wdata = 32'd0;

  // One bus cycle starting just after a negedge; ev = {run, hit, miss}.
  task automatic tick(input logic sel, input logic [1:0] tr, input logic wr_i,
                      input logic [2:0] sz, input logic [2:0] off, input logic [31:0] wd,
                      input logic [2:0] ev);
    logic [31:0] a;
    logic is_rd;
    HWDATA = nxt_wdata;
    a = $urandom;
    a[4:2] = off;
    HSEL = sel; HTRANS = tr; HWRITE = wr_i; HSIZE = sz; HADDR = a;
    nxt_wdata = wd;
    {mpc_run_m, dcc_pm_dhit_m, dcc_dmiss_m} = ev;
    is_rd = sel && tr[1] && !wr_i;
    @(negedge HCLK);
    chk("perf_irq", {31'd0, perf_irq}, {31'd0, m_irq});
    chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("hresp", {31'd0, HRESP}, 32'd0);
    if (is_rd) chk($sformatf("rd_off%0d", off), HRDATA, m_reg(off));
  endtask

  task automatic idle(input logic [2:0] ev);
    tick(1'b0, 2'b00, 1'b0, 3'b010, 3'd0, $urandom, ev);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [2:0] ev);
    tick(1'b1, 2'b10, 1'b1, 3'b010, off, d, ev);
  endtask

  task automatic rd(input logic [2:0] off, input logic [2:0] ev);
    tick(1'b1, 2'b10, 1'b0, 3'b010, off, $urandom, ev);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] base_hit, base_cyc;
    logic [2:0]  ev;
    int op;
    #1 HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_irq", {31'd0, perf_irq}, 32'd0);

    // Reset lands in the data phase of a CTRL=0 write, which must be dropped.
    wr(3'd0, 32'h0, 3'b000);
    HWDATA = 32'd0; HSEL = 1'b0; HTRANS = 2'b00; nxt_wdata = 32'd0;
    #2 HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    chk("rst2_hrdata", HRDATA, 32'd0);
    for (int o = 0; o < 8; o++) begin
      rd(3'(o), 3'b000);
      chk($sformatf("rst_reg%0d", o), HRDATA, (o == 0) ? 32'h1 : 32'h0);
    end

    // Basic counting
    wr(3'd0, 32'h7, 3'b000);
    idle(3'b000);
    for (int i = 0; i < 100; i++) begin
      ev[2] = (i < 60);
      ev[1] = (i < 25);
      ev[0] = (i == 70) || (i >= 75 && i < 80) || (i >= 85 && i < 95);
      idle(ev);
    end
    wr(3'd0, 32'h3, 3'b000);
    idle(3'b000);
    rd(3'd3, 3'b000); chk("basic_hit", HRDATA, 32'd25);
    rd(3'd4, 3'b000); chk("basic_miss", HRDATA, 32'd3);
    rd(3'd5, 3'b000); chk("basic_run", HRDATA, 32'd60);
    rd(3'd2, 3'b000); chk("basic_cyc", HRDATA, 32'd101);

    // Enable gating
    wr(3'd0, 32'h0, 3'b000);
    idle(3'b000);
    wr(3'd0, 32'h2, 3'b000);
    idle(3'b000);
    base_hit = m_shadow[1];
    base_cyc = m_shadow[0];
    repeat (50) idle(3'b110);
    wr(3'd0, 32'h2, 3'b000);
    idle(3'b000);
    rd(3'd3, 3'b000); chk("gate_hit", HRDATA, base_hit);
    rd(3'd2, 3'b000); chk("gate_cyc", HRDATA, base_cyc);

    // Back-to-back write/read, then wrap and interrupt
    wr(3'd0, 32'h9, 3'b000);
    rd(3'd0, 3'b000); chk("b2b_ctrl", HRDATA, 32'h9);
    idle(3'b000);
    force dut.cyc_q = 32'hFFFF_FFFD;
    m_live[0] = 32'hFFFF_FFFD;
    #1 release dut.cyc_q;
    idle(3'b000);
    idle(3'b000);
    idle(3'b000);
    chk("irq_not_yet", {31'd0, perf_irq}, 32'd0);
    idle(3'b000);
    chk("irq_set", {31'd0, perf_irq}, 32'd1);
    rd(3'd1, 3'b000); chk("wrap_status", HRDATA, 32'h1);
    wr(3'd1, 32'h1, 3'b000);
    idle(3'b000);
    chk("irq_hold", {31'd0, perf_irq}, 32'd1);
    idle(3'b000);
    chk("irq_clr", {31'd0, perf_irq}, 32'd0);
    rd(3'd1, 3'b000); chk("status_clr", HRDATA, 32'h0);
    idle(3'b000);
    force dut.cyc_q = 32'hFFFF_FFFE;
    m_live[0] = 32'hFFFF_FFFE;
    #1 release dut.cyc_q;
    wr(3'd1, 32'h1, 3'b000);
    idle(3'b000);
    rd(3'd1, 3'b000); chk("w1c_vs_wrap", HRDATA, 32'h1);
    wr(3'd1, 32'hF, 3'b000);
    idle(3'b000);

    // Simultaneous EN|SNAP|CLR with a hit in the write cycle
    wr(3'd0, 32'h5, 3'b000);
    idle(3'b000);
    repeat (41) idle(3'b110);
    wr(3'd0, 32'h7, 3'b110);
    rd(3'd3, 3'b110); chk("simul_shadow_hit", HRDATA, 32'd42);
    repeat (3) idle(3'b110);
    wr(3'd0, 32'h3, 3'b000);
    idle(3'b000);
    rd(3'd3, 3'b000); chk("simul_after_hit", HRDATA, 32'd3);

    // Bus protocol corner cases
    tick(1'b1, 2'b10, 1'b1, 3'b000, 3'd0, 32'h0, 3'b000);
    idle(3'b000);
    rd(3'd0, 3'b000); chk("byte_wr_ignored", HRDATA, 32'h1);
    wr(3'd3, 32'hDEAD_BEEF, 3'b000);
    idle(3'b000);
    rd(3'd3, 3'b000); chk("ro_wr_ignored", HRDATA, 32'd3);
    rd(3'd7, 3'b000); chk("off1c_zero", HRDATA, 32'd0);
    tick(1'b1, 2'b00, 1'b1, 3'b010, 3'd0, 32'h0, 3'b000);
    tick(1'b1, 2'b01, 1'b1, 3'b010, 3'd0, 32'h0, 3'b000);
    tick(1'b0, 2'b10, 1'b1, 3'b010, 3'd0, 32'h0, 3'b000);
    idle(3'b000);
    chk("idle_hold_hrdata", HRDATA, 32'd0);
    rd(3'd0, 3'b000); chk("idle_wr_ignored", HRDATA, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      op = $urandom_range(0, 9);
      ev = 3'($urandom);
      if (i == 300) begin
        force dut.run_q = 32'hFFFF_FFF0;
        m_live[3] = 32'hFFFF_FFF0;
        #1 release dut.run_q;
      end
      case (op)
        0, 1, 2: tick(1'($urandom), {1'b0, 1'($urandom)}, 1'($urandom), 3'($urandom),
                      3'($urandom), $urandom, ev);
        3, 4, 5: rd(3'($urandom_range(0, 7)), ev);
        6:       wr(3'd0, $urandom, ev);
        7:       wr(3'd1, $urandom, ev);
        8:       wr(3'($urandom_range(2, 7)), $urandom, ev);
        default: tick(1'b1, 2'b10, 1'b1, 3'($urandom_range(0, 1)), 3'($urandom_range(0, 1)),
                      $urandom, ev);
      endcase
    end
    for (int o = 0; o < 6; o++) rd(3'(o), 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_cache_perf.md
# mfp_ahb_cache_perf

AHB-Lite slave performance-counter peripheral for the basic-caching system. It consumes the core's pipeline and data-cache event strobes (`mpc_run_m`, `dcc_pm_dhit_m`, `dcc_dmiss_m`) and counts cycles, hits, misses and run cycles. Software controls the counters and reads atomic snapshots over the bus. The block sits on the AHB-Lite bus beside the GPIO/UART slaves and is selected by the bus decoder via `HSEL`.

## Interface
- `EN_AT_RESET`, default 1: value of `CTRL.EN` after reset.
- `HCLK`, input, 1: bus/core clock; all state on the rising edge.
- `HRESETn`, input, 1: reset, asynchronous, active-low.
- `HSEL`, input, 1: slave select from the bus decoder.
- `HADDR`, input, 32: address; only [4:2] decoded.
- `HTRANS`, input, 2: transfer type; NONSEQ/SEQ when `HTRANS[1]`=1.
- `HWRITE`, input, 1: 1 = write.
- `HSIZE`, input, 3: transfer size; only 3'b010 writes take effect.
- `HWDATA`, input, 32: write data, valid in the data phase.
- `HREADY`, input, 1: bus ready; qualifies the address phase.
- `HRDATA`, output, 32: read data.
- `HREADYOUT`, output, 1: tied to 1 (zero wait states).
- `HRESP`, output, 1: tied to 0 (OKAY).
- `mpc_run_m`, input, 1: M-stage advancing.
- `dcc_pm_dhit_m`, input, 1: D$ hit in M.
- `dcc_dmiss_m`, input, 1: D$ miss in M; held high across the miss stall.
- `perf_irq`, output, 1: registered interrupt.

## Operation
- **Address phase accept:** when `HSEL & HREADY & HTRANS[1]`, register `HADDR[4:2]`, `HWRITE`, and (`HSIZE`==3'b010) as data-phase controls.
- **Register map (word offsets):**
  - 0x00 CTRL, RW: [0] EN, [1] SNAP, [2] CLR, [3] IRQ_EN. SNAP and CLR are self-clearing pulses and read as 0.
  - 0x04 STATUS, RW1C: [3:0] sticky overflow flags for CYC, HIT, MISS, RUN.
  - 0x08 CYC, 0x0C HIT, 0x10 MISS, 0x14 RUN: read-only shadow copies.
  - 0x18 and 0x1C: read 0.
  - Writes to read-only offsets are ignored.
- **Live counters:** four 32-bit counters. While EN=1, each cycle:
  - CYC += 1.
  - HIT += (`dcc_pm_dhit_m & mpc_run_m`).
  - MISS += (`dcc_dmiss_m & ~miss_d`), where `miss_d` is `dcc_dmiss_m` delayed one cycle. One count per miss, however long the stall.
  - RUN += `mpc_run_m`.
  - `miss_d` updates regardless of EN.
- **Wrap:** each counter wraps 0xFFFFFFFF→0 and sets its STATUS flag that same edge.
- **SNAP:** copies all four live counters into the shadows in one edge, using their pre-increment values. Shadows otherwise hold.
- **CLR:** zeroes the live counters and `miss_d`. Shadows and STATUS are not affected.
- **SNAP and CLR written together:** shadows capture the pre-clear values, then the live counters clear.
- **CLR and an event in the same cycle:** CLR wins; the counter reads 0.
- **STATUS W1C and a new overflow on the same bit in the same cycle:** the set wins.
- **`perf_irq`:** registered `IRQ_EN & |STATUS`.

## Timing
- **Reset values:**
  - CTRL = {IRQ_EN 0, CLR 0, SNAP 0, EN `EN_AT_RESET`}.
  - STATUS, live counters, shadows, `miss_d` = 0.
  - `perf_irq` = 0; the registered address-phase controls clear.
  - `HRDATA` = 0.
- **Reset mid-operation:** async reset clears everything immediately, including a pending data-phase write, which is dropped.
- **Writes:** take effect on the HCLK edge that ends the data phase.
  - CTRL.EN gates counting from the following cycle.
  - SNAP/CLR act on that same edge and are not stored.
- **Reads:** `HRDATA` is a combinational mux of the data-phase registered offset. It is valid throughout the data phase.
  - A read in the data phase right after a SNAP write returns the new shadow.
- **`perf_irq`:** asserts one cycle after the STATUS bit sets and deasserts one cycle after the W1C clears it.
- **Back-to-back transfers:** pipelined transfers are supported with no bubbles. A write followed immediately by a read of the same register returns the written value (CTRL) or the updated value (STATUS).
- **IDLE/BUSY or HSEL=0:** no register changes; `HRDATA` keeps its last mux value.

## Test plan
- **Reset/defaults:** assert `HRESETn`=0 mid-transfer, then release. Every readable register reads 0 except CTRL=0x1. `perf_irq`=0; `HREADYOUT`=1, `HRESP`=0 at all times.
- **Basic counting:** CLR+SNAP, then run 100 cycles with `mpc_run_m` high on 60 cycles, hit&run on 25, and 3 misses held 1, 5 and 10 cycles. SNAP; CYC≈100 (exact per write-edge timing), RUN=60, HIT=25, MISS=3.
- **Enable gating:** write EN=0, drive 50 hits, then SNAP. HIT is unchanged and CYC is unchanged.
- **Wrap/overflow/IRQ:** set IRQ_EN; let CYC wrap (use a force or a long run).
  - STATUS[0]=1 and `perf_irq`=1 one cycle later.
  - Write STATUS=0x1 → STATUS=0 and `perf_irq`=0 next cycle.
  - W1C coincident with a new wrap keeps the bit at 1.
- **Simultaneous control:** write CTRL=0x7 (EN|SNAP|CLR) with live HIT=42 and a hit in that cycle.
  - Shadow HIT reads 42.
  - Live HIT is 0 after the edge; the next SNAP shows only hits that occurred after the write.
- **Bus protocol:**
  - Byte write (`HSIZE`=0) to CTRL → ignored.
  - Write to HIT offset → ignored.
  - Back-to-back write CTRL=0x9 then read CTRL → 0x9.
  - Read of offset 0x1C → 0.
